mole_game_ctrl: RTL

MOLE_GAME_CTRL -- requirements
Module: mole_game_ctrl

---
 rtl/mole_pkg.sv | 36 +++
 rtl/mole_game_ctrl_if.sv | 21 ++
 rtl/mole_game_ctrl_buzzer_pulse.sv | 32 +++
 rtl/mole_game_ctrl.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/mole_pkg.sv
// Shared types and constants for the whack-a-mole game controller.
package mole_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SHOW = 2'd1,
      ST_GAP  = 2'd2,
      ST_OVER = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      SPD_NORM = 2'd0,
      SPD_FAST = 2'd1,
      SPD_SLOW = 2'd2
   } speed_t;

   localparam logic [4:0] KEY_NORM  = 5'd11;
   localparam logic [4:0] KEY_FAST  = 5'd12;
   localparam logic [4:0] KEY_SLOW  = 5'd13;
   localparam logic [4:0] KEY_STOP  = 5'd14;
   localparam logic [4:0] KEY_START = 5'd15;
   localparam logic [4:0] KEY_NONE  = 5'd16;

   // LED pattern for a mole at position p
   function automatic logic [7:0] onehot8(input logic [2:0] p);
      return 8'b1 << p;
   endfunction

   // Saturating 8-bit add of a small increment
   function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [1:0] b);
      logic [8:0] s;
      s = {1'b0, a} + {7'b0, b};
      return s[8] ? 8'hFF : s[7:0];
   endfunction

endpackage

// File: rtl/mole_game_ctrl_if.sv
// Player-side signals of the game controller: keypad, random source, display.
interface mole_game_ctrl_if;
   logic       key_valid;
   logic [4:0] key_code;
   logic [2:0] rand_in;
   logic [7:0] led;
   logic       buzzer;
   logic [7:0] score;
   logic       game_over;
   logic [1:0] state_o;

   modport master (
      output key_valid, key_code, rand_in,
      input  led, buzzer, score, game_over, state_o
   );

   modport slave (
      input  key_valid, key_code, rand_in,
      output led, buzzer, score, game_over, state_o
   );
endinterface

// File: rtl/mole_game_ctrl_buzzer_pulse.sv
// Retriggerable pulse: out stays high for length cycles after the last load.
module buzzer_pulse #(
   parameter int unsigned W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load_i,
   input  logic         clr_i,
   input  logic [W-1:0] length_i,
   output logic         out_o
);
   logic [W-1:0] cnt_q, cnt_d;

   // clear beats reload, reload beats countdown
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)              cnt_d = '0;
      else if (load_i)        cnt_d = length_i;
      else if (cnt_q != '0)   cnt_d = cnt_q - W'(1);
   end

   // count register and registered enable
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         out_o <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         out_o <= (cnt_d != '0);
      end
   end
endmodule

// File: rtl/mole_game_ctrl.sv
// Whack-a-mole game sequencer: mole timing, scoring, misses and game end.
module mole_game_ctrl import mole_pkg::*; #(
   parameter int unsigned T_FAST   = 50_000_000,
   parameter int unsigned T_NORM   = 200_000_000,
   parameter int unsigned T_SLOW   = 400_000_000,
   parameter int unsigned T_GAP    = 10_000_000,
   parameter int unsigned T_BUZZ   = 10_000_000,
   parameter int unsigned ROUNDS   = 30,
   parameter int unsigned MAX_MISS = 5
) (
   input  logic            clk,
   input  logic            rst_n,
   mole_game_ctrl_if.slave bus
);
   // timers compare against the last cycle of each phase
   localparam logic [31:0] LIM_FAST = 32'(T_FAST) - 32'd1;
   localparam logic [31:0] LIM_NORM = 32'(T_NORM) - 32'd1;
   localparam logic [31:0] LIM_SLOW = 32'(T_SLOW) - 32'd1;
   localparam logic [31:0] LIM_GAP  = 32'(T_GAP)  - 32'd1;
   localparam logic [31:0] BUZ_LEN  = 32'(T_BUZZ);
   localparam logic [7:0]  ROUNDS_C = 8'(ROUNDS);
   localparam logic [7:0]  MISS_C   = 8'(MAX_MISS);

   state_t      state_q, state_d;
   speed_t      speed_q, speed_d;
   logic [2:0]  pos_q, pos_d;
   logic [31:0] timer_q, timer_d;
   logic [7:0]  score_q, score_d;
   logic [7:0]  round_q, round_d;
   logic [7:0]  miss_q, miss_d;
   logic [7:0]  led_q, led_d;
   logic        over_q, over_d;
   logic        hit_ok, buz_load, buz_clr, buz_out;
   logic [31:0] show_lim;

   logic       kv;
   logic [4:0] kc;
   logic       key_stop, key_start, key_lo, key_hit, key_wrong, show_tmo;

   assign kv        = bus.key_valid;
   assign kc        = bus.key_code;
   assign key_stop  = kv && (kc == KEY_STOP);
   assign key_start = kv && (kc == KEY_START);
   assign key_lo    = kv && (kc < 5'd8);
   assign key_hit   = key_lo && (kc[2:0] == pos_q);
   assign key_wrong = key_lo && (kc[2:0] != pos_q);
   assign show_tmo  = (timer_q == show_lim);

   // mole display limit for the selected speed
   always_comb begin
      case (speed_q)
         SPD_FAST: show_lim = LIM_FAST;
         SPD_SLOW: show_lim = LIM_SLOW;
         default:  show_lim = LIM_NORM;
      endcase
   end

   // state and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         speed_q <= SPD_NORM;
         pos_q   <= '0;
         timer_q <= '0;
         score_q <= '0;
         round_q <= '0;
         miss_q  <= '0;
         led_q   <= '0;
         over_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         speed_q <= speed_d;
         pos_q   <= pos_d;
         timer_q <= timer_d;
         score_q <= score_d;
         round_q <= round_d;
         miss_q  <= miss_d;
         led_q   <= led_d;
         over_q  <= over_d;
      end
   end

   // next state: stop key outranks a hit, a hit outranks a timeout
   always_comb begin
      state_d = state_q;
      speed_d = speed_q;
      pos_d   = pos_q;
      timer_d = timer_q;
      score_d = score_q;
      round_d = round_q;
      miss_d  = miss_q;
      hit_ok  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (kv) begin
               case (kc)
                  KEY_FAST: speed_d = SPD_FAST;
                  KEY_SLOW: speed_d = SPD_SLOW;
                  KEY_NORM: speed_d = SPD_NORM;
                  KEY_START: begin
                     score_d = '0;
                     round_d = '0;
                     miss_d  = '0;
                     pos_d   = bus.rand_in;
                     timer_d = '0;
                     state_d = ST_SHOW;
                  end
                  default: ;
               endcase
            end
         end
         ST_SHOW: begin
            timer_d = timer_q + 32'd1;
            if (key_stop) begin
               state_d = ST_OVER;
            end else if (key_hit) begin
               hit_ok  = 1'b1;
               score_d = sat_add8(score_q, 2'd1);
               round_d = sat_add8(round_q, 2'd1);
               timer_d = '0;
               state_d = (round_d >= ROUNDS_C || miss_q >= MISS_C) ? ST_OVER : ST_GAP;
            end else begin
               // a wrong key and a timeout in one cycle count as two misses
               miss_d = sat_add8(miss_q, {1'b0, key_wrong} + {1'b0, show_tmo});
               if (show_tmo) begin
                  round_d = sat_add8(round_q, 2'd1);
                  timer_d = '0;
                  state_d = (round_d >= ROUNDS_C || miss_d >= MISS_C) ? ST_OVER : ST_GAP;
               end
            end
         end
         ST_GAP: begin
            timer_d = timer_q + 32'd1;
            if (key_stop) begin
               state_d = ST_OVER;
            end else if (timer_q == LIM_GAP) begin
               // never show the mole in the same hole twice in a row
               pos_d   = (bus.rand_in == pos_q) ? bus.rand_in + 3'd1 : bus.rand_in;
               timer_d = '0;
               state_d = ST_SHOW;
            end
         end
         ST_OVER: begin
            if (key_start) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // registered outputs are derived from the upcoming state
   always_comb begin
      led_d    = '0;
      over_d   = 1'b0;
      buz_load = hit_ok;
      buz_clr  = (state_d == ST_IDLE) || (state_d == ST_OVER);
      case (state_d)
         ST_SHOW: led_d = onehot8(pos_d);
         ST_OVER: begin
            led_d  = score_d;
            over_d = 1'b1;
         end
         default: ;
      endcase
   end

   buzzer_pulse #(.W(32)) u_buzz (
      .clk      (clk),
      .rst_n    (rst_n),
      .load_i   (buz_load),
      .clr_i    (buz_clr),
      .length_i (BUZ_LEN),
      .out_o    (buz_out)
   );

   assign bus.led       = led_q;
   assign bus.buzzer    = buz_out;
   assign bus.score     = score_q;
   assign bus.game_over = over_q;
   assign bus.state_o   = state_q;
endmodule
